instruction_fetch_queue: RTL

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: single-outstanding cache fetcher feeding a circular {pc, instr} FIFO.
// Optional misaligned-redirect checking is enabled with `define IFQ_MISALIGN_CHK_EN.
module instruction_fetch_queue #(
   parameter int               DEPTH     = 4,
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = 32'h00000000,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    redirect,
   input  logic [XLEN-1:0]         redirect_target,
   input  logic                    target_mod2,
   input  logic                    id_ready,
   output logic                    id_valid,
   output logic [XLEN-1:0]         id_pc,
   output logic [XLEN-1:0]         id_instr,
   output logic                    inst_read,
   output logic [XLEN-1:0]         inst_addr,
   input  logic                    inst_resp,
   input  logic [XLEN-1:0]         inst_rdata,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    misalign_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic            out_q, out_d;
   logic            drop_q, drop_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] eff_tgt, tgt;
   logic            resp_fire, push, pop, free, start;

   assign eff_tgt = {redirect_target[XLEN-1:1], redirect_target[0] & ~target_mod2};

`ifdef IFQ_MISALIGN_CHK_EN
   // Misaligned target is still loaded, but fetch stays halted until an aligned redirect.
   assign tgt   = eff_tgt;
   assign mis_d = redirect ? (eff_tgt[1:0] != 2'b00) : mis_q;
`else
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   assign tgt   = eff_tgt & ALIGN_MASK;
   assign mis_d = 1'b0;
`endif

   assign id_valid     = (count_q != '0);
   assign id_pc        = mem_q[head_q].pc;
   assign id_instr     = id_valid ? mem_q[head_q].instr : NOP_INSTR;
   assign inst_read    = out_q;
   assign inst_addr    = req_addr_q;
   assign occupancy    = count_q;
   assign misalign_err = mis_q;

   // Redirect wins over push and pop; a response arriving with redirect is discarded.
   assign resp_fire = out_q & inst_resp;
   assign push      = resp_fire & ~drop_q & ~redirect;
   assign pop       = id_ready & id_valid & ~redirect;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = tgt;
      end else begin
         if (push) begin
            tail_d     = tail_q + PW'(1);
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (pop) head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // The slot frees on the response cycle, so the next request can follow back-to-back.
   assign free  = ~out_q | resp_fire;
   assign start = free & (count_d < CW'(DEPTH)) & ~mis_d;

   always_comb begin
      out_d      = out_q;
      drop_d     = drop_q;
      req_addr_d = req_addr_q;
      if (start) begin
         out_d      = 1'b1;
         drop_d     = 1'b0;
         req_addr_d = fetch_pc_d;
      end else if (free) begin
         out_d  = 1'b0;
         drop_d = 1'b0;
      end else begin
         drop_d = drop_q | redirect;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         out_q      <= 1'b0;
         drop_q     <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         mis_q      <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= '{pc: req_addr_q, instr: inst_rdata};
   end

endmodule
